// File: rtl/sdram_rd_fifo_ctrl.sv
// Read-side prefetch controller: issues burst reads over a circular address
// window and buffers the returned words in a synchronous FIFO for user pops.
module sdram_rd_fifo_ctrl #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 24,
  parameter int DEPTH  = 512,
  parameter int LVL_W  = 10
) (
  input  logic              fifo_clk,
  input  logic              fifo_rst_n,
  input  logic [ADDR_W-1:0] rd_start_addr,
  input  logic [ADDR_W-1:0] rd_end_addr,
  input  logic [9:0]        rd_bst_len,
  input  logic              read_valid,
  input  logic              rd_flush,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_ack,
  input  logic [DATA_W-1:0] rd_sdram_data,
  input  logic              rd_end,
  input  logic              usr_rd_en,
  output logic [DATA_W-1:0] usr_rd_data,
  output logic              usr_rd_valid,
  output logic [LVL_W-1:0]  fifo_level,
  output logic              fifo_empty
);

  localparam int PTR_W = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    UPD
  } state_t;

  state_t state, state_nxt;

  logic              addr_vld, addr_vld_nxt;
  logic              flush_pend, flush_pend_nxt;
  logic              rd_en_nxt;
  logic [ADDR_W-1:0] rd_addr_nxt;
  logic              fifo_clr;
  logic [LVL_W:0]    need;
  logic [ADDR_W:0]   nxt_addr;
  logic [ADDR_W:0]   nxt_last;

  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              push, pop;
  logic [LVL_W-1:0]  level_nxt;

  // Request sequencing: a flush during a burst is deferred until rd_end so the
  // engine always sees a complete request/complete handshake.
  always_comb begin
    state_nxt      = state;
    addr_vld_nxt   = addr_vld;
    flush_pend_nxt = flush_pend;
    rd_en_nxt      = rd_en;
    rd_addr_nxt    = rd_addr;
    fifo_clr       = 1'b0;
    nxt_addr       = {1'b0, rd_addr} + (ADDR_W+1)'(rd_bst_len);
    nxt_last       = nxt_addr + (ADDR_W+1)'(rd_bst_len) - (ADDR_W+1)'(1);
    need           = (LVL_W+1)'(fifo_level) + (LVL_W+1)'(rd_bst_len);

    case (state)
      IDLE: begin
        if (rd_flush) begin
          fifo_clr     = 1'b1;
          addr_vld_nxt = 1'b0;
        end else if (!addr_vld) begin
          rd_addr_nxt  = rd_start_addr;
          addr_vld_nxt = 1'b1;
        end else if (read_valid && (rd_bst_len != 10'd0) &&
                     (need <= (LVL_W+1)'(DEPTH))) begin
          rd_en_nxt = 1'b1;
          state_nxt = REQ;
        end
      end
      REQ: begin
        if (rd_end) begin
          rd_en_nxt = 1'b0;
          if (flush_pend || rd_flush) begin
            fifo_clr       = 1'b1;
            addr_vld_nxt   = 1'b0;
            flush_pend_nxt = 1'b0;
            state_nxt      = IDLE;
          end else begin
            state_nxt = UPD;
          end
        end else if (rd_flush) begin
          flush_pend_nxt = 1'b1;
        end
      end
      UPD: begin
        state_nxt = IDLE;
        if (rd_flush) begin
          fifo_clr     = 1'b1;
          addr_vld_nxt = 1'b0;
        end else if (nxt_last > {1'b0, rd_end_addr}) begin
          rd_addr_nxt = rd_start_addr;
        end else begin
          rd_addr_nxt = nxt_addr[ADDR_W-1:0];
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Pops are discarded on any flush cycle; a full FIFO only accepts a push
  // when a pop frees a slot in the same cycle.
  always_comb begin
    pop  = usr_rd_en && !fifo_empty && !rd_flush && !fifo_clr;
    push = (state == REQ) && rd_ack && !flush_pend && !rd_flush && !fifo_clr &&
           ((fifo_level != LVL_W'(DEPTH)) || pop);
    level_nxt = fifo_level;
    if (push && !pop) begin
      level_nxt = fifo_level + LVL_W'(1);
    end else if (pop && !push) begin
      level_nxt = fifo_level - LVL_W'(1);
    end
  end

  always_ff @(posedge fifo_clk or negedge fifo_rst_n) begin
    if (!fifo_rst_n) begin
      state        <= IDLE;
      addr_vld     <= 1'b0;
      flush_pend   <= 1'b0;
      rd_en        <= 1'b0;
      rd_addr      <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fifo_level   <= '0;
      fifo_empty   <= 1'b1;
      usr_rd_data  <= '0;
      usr_rd_valid <= 1'b0;
    end else begin
      state        <= state_nxt;
      addr_vld     <= addr_vld_nxt;
      flush_pend   <= flush_pend_nxt;
      rd_en        <= rd_en_nxt;
      rd_addr      <= rd_addr_nxt;
      usr_rd_valid <= pop;
      if (pop) begin
        usr_rd_data <= mem[rd_ptr];
      end
      if (fifo_clr) begin
        wr_ptr     <= '0;
        rd_ptr     <= '0;
        fifo_level <= '0;
        fifo_empty <= 1'b1;
      end else begin
        if (push) begin
          wr_ptr <= wr_ptr + PTR_W'(1);
        end
        if (pop) begin
          rd_ptr <= rd_ptr + PTR_W'(1);
        end
        fifo_level <= level_nxt;
        fifo_empty <= (level_nxt == '0);
      end
    end
  end

  // Storage array has no reset; the pointers define which entries are live.
  always_ff @(posedge fifo_clk) begin
    if (push) begin
      mem[wr_ptr] <= rd_sdram_data;
    end
  end

endmodule

// File: tb/tb_sdram_rd_fifo_ctrl.sv
// Self-checking bench: behavioural burst engine plus a queue-based reference
// model of the prefetch FIFO, driven with randomized pops and ack gaps.
module tb_sdram_rd_fifo_ctrl;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 24;
  localparam int DEPTH  = 512;
  localparam int LVL_W  = 10;

  logic              fifo_clk = 1'b0;
  logic              fifo_rst_n;
  logic [ADDR_W-1:0] rd_start_addr;
  logic [ADDR_W-1:0] rd_end_addr;
  logic [9:0]        rd_bst_len;
  logic              read_valid;
  logic              rd_flush;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_ack;
  logic [DATA_W-1:0] rd_sdram_data;
  logic              rd_end;
  logic              usr_rd_en;
  logic [DATA_W-1:0] usr_rd_data;
  logic              usr_rd_valid;
  logic [LVL_W-1:0]  fifo_level;
  logic              fifo_empty;

  sdram_rd_fifo_ctrl #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .LVL_W(LVL_W)
  ) dut (
    .fifo_clk     (fifo_clk),
    .fifo_rst_n   (fifo_rst_n),
    .rd_start_addr(rd_start_addr),
    .rd_end_addr  (rd_end_addr),
    .rd_bst_len   (rd_bst_len),
    .read_valid   (read_valid),
    .rd_flush     (rd_flush),
    .rd_en        (rd_en),
    .rd_addr      (rd_addr),
    .rd_ack       (rd_ack),
    .rd_sdram_data(rd_sdram_data),
    .rd_end       (rd_end),
    .usr_rd_en    (usr_rd_en),
    .usr_rd_data  (usr_rd_data),
    .usr_rd_valid (usr_rd_valid),
    .fifo_level   (fifo_level),
    .fifo_empty   (fifo_empty)
  );

  always #5 fifo_clk = ~fifo_clk;

  int tests_run    = 0;
  int tests_failed = 0;

  // reference model state
  logic [DATA_W-1:0] exp_q[$];
  int                exp_addr;
  bit                m_flush_pend;
  bit                exp_valid;
  logic [DATA_W-1:0] exp_data;
  int                req_count;
  int                addr_log[$];

  // engine model state
  bit eng_busy;
  bit eng_gaps;
  int eng_wait;
  int eng_cnt;
  int eng_addr;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: observed %0h expected %0h at %0t", tag,
               observed, expected, $time);
    end
  endtask

  function automatic int next_addr(input int a);
    int s, e, l;
    s = int'(rd_start_addr);
    e = int'(rd_end_addr);
    l = int'(rd_bst_len);
    if (a + 2 * l - 1 > e) return s;
    return a + l;
  endfunction

  function automatic logic [DATA_W-1:0] word_of(input int a);
    return DATA_W'(a * 13) ^ 16'hC3A5;
  endfunction

  // One clock cycle: engine reacts to rd_en, inputs are applied, the model
  // advances at the edge and outputs are compared 1 ns later.
  task automatic applyStimulus(input bit pop, input bit flush);
    bit                in_req, ack, endp;
    logic [DATA_W-1:0] d;
    in_req = rd_en;
    ack    = 1'b0;
    endp   = 1'b0;
    d      = '0;
    if (eng_busy) checkOutput("rd_en_held", 32'(rd_en), 32'd1);
    if (!eng_busy && rd_en) begin
      eng_busy = 1'b1;
      eng_addr = int'(rd_addr);
      eng_cnt  = 0;
      eng_wait = $urandom_range(0, 2);
      req_count++;
      addr_log.push_back(int'(rd_addr));
      checkOutput("req_addr", 32'(rd_addr), 32'(exp_addr));
      checkOutput("headroom", 32'(exp_q.size() + int'(rd_bst_len) <= DEPTH), 32'd1);
    end
    if (eng_busy) begin
      if (eng_wait > 0) begin
        eng_wait--;
      end else if (eng_cnt < int'(rd_bst_len)) begin
        if (!eng_gaps || $urandom_range(0, 3) != 0) begin
          ack = 1'b1;
          d   = word_of(eng_addr + eng_cnt);
          eng_cnt++;
        end
      end else begin
        endp     = 1'b1;
        eng_busy = 1'b0;
      end
    end else if (!in_req && $urandom_range(0, 7) == 0) begin
      ack = 1'b1;
      d   = 16'hDEAD;
    end
    rd_ack        = ack;
    rd_end        = endp;
    rd_sdram_data = d;
    usr_rd_en     = pop;
    rd_flush      = flush;
    @(posedge fifo_clk);
    exp_valid = 1'b0;
    if (pop && exp_q.size() > 0 && !flush && !(in_req && endp && m_flush_pend)) begin
      exp_data  = exp_q.pop_front();
      exp_valid = 1'b1;
    end
    if (in_req && ack && !m_flush_pend && !flush) begin
      checkOutput("no_overflow", 32'(exp_q.size() < DEPTH), 32'd1);
      exp_q.push_back(d);
    end
    if (flush) begin
      if (in_req) begin
        m_flush_pend = 1'b1;
      end else begin
        exp_q.delete();
        exp_addr = int'(rd_start_addr);
      end
    end
    if (in_req && endp) begin
      if (m_flush_pend) begin
        exp_q.delete();
        m_flush_pend = 1'b0;
        exp_addr     = int'(rd_start_addr);
      end else begin
        exp_addr = next_addr(exp_addr);
      end
    end
    #1;
    checkOutput("rd_valid", 32'(usr_rd_valid), 32'(exp_valid));
    if (exp_valid) checkOutput("rd_data", 32'(usr_rd_data), 32'(exp_data));
    checkOutput("level", 32'(fifo_level), 32'(exp_q.size()));
    checkOutput("empty", 32'(fifo_empty), 32'(exp_q.size() == 0));
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_rd_en"}, 32'(rd_en), 32'd0);
    checkOutput({tag, "_rd_addr"}, 32'(rd_addr), 32'd0);
    checkOutput({tag, "_valid"}, 32'(usr_rd_valid), 32'd0);
    checkOutput({tag, "_data"}, 32'(usr_rd_data), 32'd0);
    checkOutput({tag, "_level"}, 32'(fifo_level), 32'd0);
    checkOutput({tag, "_empty"}, 32'(fifo_empty), 32'd1);
  endtask

  task automatic clearModel();
    exp_q.delete();
    addr_log.delete();
    exp_addr     = int'(rd_start_addr);
    m_flush_pend = 1'b0;
    exp_valid    = 1'b0;
    req_count    = 0;
    eng_busy     = 1'b0;
    eng_cnt      = 0;
    eng_wait     = 0;
  endtask

  task automatic resetDut(input int s, input int e, input int l);
    fifo_rst_n    = 1'b0;
    rd_ack        = 1'b0;
    rd_end        = 1'b0;
    rd_flush      = 1'b0;
    usr_rd_en     = 1'b0;
    rd_sdram_data = '0;
    rd_start_addr = ADDR_W'(s);
    rd_end_addr   = ADDR_W'(e);
    rd_bst_len    = 10'(l);
    repeat (2) @(posedge fifo_clk);
    #1;
    checkResetOutputs("reset");
    clearModel();
    @(negedge fifo_clk);
    fifo_rst_n = 1'b1;
  endtask

  task automatic runUntilReqs(input int n, input int pop_pct, input int budget);
    for (int i = 0; i < budget && req_count < n; i++)
      applyStimulus($urandom_range(0, 99) < pop_pct, 1'b0);
    checkOutput("req_count", 32'(req_count), 32'(n));
  endtask

  initial begin
    int base;
    fifo_rst_n = 1'b1;
    read_valid = 1'b1;
    eng_gaps   = 1'b0;

    // no pops: two bursts fill the FIFO, then headroom blocks a third
    resetDut(0, 1023, 256);
    for (int i = 0; i < 700; i++) applyStimulus(1'b0, 1'b0);
    checkOutput("t1_reqs", 32'(req_count), 32'd2);
    checkOutput("t1_full", 32'(fifo_level), 32'd512);
    if (addr_log.size() >= 2) begin
      checkOutput("t1_addr0", 32'(addr_log[0]), 32'd0);
      checkOutput("t1_addr1", 32'(addr_log[1]), 32'd256);
    end

    // continuous pops with gappy acks: address sequence wraps to 0
    resetDut(0, 1023, 256);
    eng_gaps = 1'b1;
    runUntilReqs(5, 100, 4000);
    if (addr_log.size() >= 5) begin
      checkOutput("t2_addr2", 32'(addr_log[2]), 32'd512);
      checkOutput("t2_addr3", 32'(addr_log[3]), 32'd768);
      checkOutput("t2_wrap", 32'(addr_log[4]), 32'd0);
    end

    // window whose tail does not hold a whole burst
    resetDut(100, 611, 256);
    runUntilReqs(3, 60, 4000);
    if (addr_log.size() >= 3) begin
      checkOutput("t3_addr0", 32'(addr_log[0]), 32'd100);
      checkOutput("t3_addr1", 32'(addr_log[1]), 32'd356);
      checkOutput("t3_wrap", 32'(addr_log[2]), 32'd100);
    end

    // flush mid-burst after 40 acks
    eng_gaps = 1'b0;
    resetDut(64, 1023, 256);
    for (int i = 0; i < 2000 && !(eng_busy && eng_cnt == 40); i++)
      applyStimulus(1'b0, 1'b0);
    checkOutput("t4_at40", 32'(eng_cnt), 32'd40);
    applyStimulus(1'b0, 1'b1);
    for (int i = 0; i < 400 && eng_busy; i++) applyStimulus(1'b0, 1'b0);
    checkOutput("t4_done", 32'(eng_busy), 32'd0);
    checkOutput("t4_level", 32'(fifo_level), 32'd0);
    base = req_count;
    runUntilReqs(base + 1, 0, 100);
    if (addr_log.size() > base)
      checkOutput("t4_restart", 32'(addr_log[base]), 32'd64);

    // pop on empty, then simultaneous push+pop at level 5
    read_valid = 1'b0;
    resetDut(0, 1023, 256);
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'b0);
    checkOutput("t5_empty_valid", 32'(usr_rd_valid), 32'd0);
    read_valid = 1'b1;
    for (int i = 0; i < 300 && exp_q.size() < 5; i++) applyStimulus(1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 1'b0);
      checkOutput("t5_level5", 32'(fifo_level), 32'd5);
    end
    for (int i = 0; i < 200; i++) applyStimulus($urandom_range(0, 1) == 1, 1'b0);

    // asynchronous reset mid-burst
    resetDut(200, 1023, 256);
    for (int i = 0; i < 2000 && !(eng_busy && eng_cnt == 30); i++)
      applyStimulus($urandom_range(0, 1) == 1, 1'b0);
    checkOutput("t6_at30", 32'(eng_cnt), 32'd30);
    #2 fifo_rst_n = 1'b0;
    #1;
    checkResetOutputs("t6_async");
    rd_ack    = 1'b0;
    usr_rd_en = 1'b0;
    clearModel();
    @(negedge fifo_clk);
    fifo_rst_n = 1'b1;
    runUntilReqs(1, 0, 100);
    if (addr_log.size() >= 1)
      checkOutput("t6_restart", 32'(addr_log[0]), 32'd200);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
